// File: rtl/pl_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit (pl_muldiv).
// Build option MULDIV_SIGNED_EN enables the signed MULT/DIV variants.
package pl_muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   localparam int MULDIV_WIDTH = 32;
   // Start edge to the edge that raises done, plus the done cycle itself
   localparam int MULDIV_LAT   = MULDIV_WIDTH + 2;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/pl_signfix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign.
module pl_signfix #(
   parameter int W = 32
) (
   input  logic         i_neg,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/pl_muldiv.sv
// Iterative 1-bit/cycle multiply/divide with HI/LO registers for the 5-stage CPU.
// Build option MULDIV_SIGNED_EN: when defined op[0]=0 selects signed MULT/DIV,
// otherwise every op is unsigned and FIX is a pass-through cycle.
module pl_muldiv
   import pl_muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_flush,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int              CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_e               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opd;
   logic                 r_div;
   logic                 r_neg_lo;
   logic                 r_neg_hi;
   logic                 r_dz;
   logic                 r_done;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   logic                 w_signed;
   logic                 w_is_div;
   logic                 w_sa;
   logic                 w_sb;
   logic                 w_fix;
   logic [WIDTH-1:0]     w_fa_in;
   logic [WIDTH-1:0]     w_fb_in;
   logic                 w_fa_neg;
   logic                 w_fb_neg;
   logic [WIDTH-1:0]     w_fa;
   logic [WIDTH-1:0]     w_fb;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH:0]       w_madd;
   logic [WIDTH:0]       w_dsub;
   logic [2*WIDTH-1:0]   w_mul_nxt;
   logic [2*WIDTH-1:0]   w_div_nxt;

`ifdef MULDIV_SIGNED_EN
   assign w_signed = ~i_op[0];
`else
   logic w_unused_op0;
   assign w_unused_op0 = i_op[0];
   assign w_signed     = 1'b0;
`endif

   assign w_is_div = op_is_div(i_op);
   assign w_sa     = w_signed & i_a[WIDTH-1];
   assign w_sb     = w_signed & i_b[WIDTH-1];
   assign w_fix    = (r_state == S_FIX);

   // The operand negators are idle in FIX, so they re-sign quotient and remainder there
   assign w_fa_in  = w_fix ? r_acc[WIDTH-1:0]       : i_a;
   assign w_fb_in  = w_fix ? r_acc[2*WIDTH-1:WIDTH] : i_b;
   assign w_fa_neg = w_fix ? (r_div & r_neg_lo)     : w_sa;
   assign w_fb_neg = w_fix ? (r_div & r_neg_hi)     : w_sb;

   pl_signfix #(.W(WIDTH)) u_fix_a (
      .i_neg (w_fa_neg),
      .i_val (w_fa_in),
      .o_val (w_fa)
   );

   pl_signfix #(.W(WIDTH)) u_fix_b (
      .i_neg (w_fb_neg),
      .i_val (w_fb_in),
      .o_val (w_fb)
   );

   pl_signfix #(.W(2*WIDTH)) u_fix_p (
      .i_neg (r_neg_lo),
      .i_val (r_acc),
      .o_val (w_prod)
   );

   // Shift-add: multiplier sits in the low half and drains out to the right
   assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opd};
   assign w_mul_nxt = r_acc[0] ? {w_madd, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

   // Restoring divide: a set top bit of the trial difference means borrow
   assign w_dsub    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opd};
   assign w_div_nxt = w_dsub[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                    : {w_dsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opd    <= '0;
         r_div    <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_dz     <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (i_hi_we) r_hi <= i_wdata;
            if (i_lo_we) r_lo <= i_wdata;
         end
         if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_state  <= S_CALC;
                     r_cnt    <= '0;
                     r_div    <= w_is_div;
                     r_neg_lo <= w_sa ^ w_sb;
                     r_neg_hi <= w_sa;
                     r_dz     <= w_is_div & (i_b == '0);
                     r_opd    <= w_is_div ? w_fb : w_fa;
                     r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_fa} : {{WIDTH{1'b0}}, w_fb};
                  end
               end
               S_CALC: begin
                  r_acc <= r_div ? w_div_nxt : w_mul_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST) r_state <= S_FIX;
               end
               S_FIX: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
                  if (r_div) begin
                     r_hi <= w_fb;
                     r_lo <= r_dz ? {WIDTH{1'b1}} : w_fa;
                  end else begin
                     {r_hi, r_lo} <= w_prod;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_busy = (r_state != S_IDLE);
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule
